// File: rtl/tile_pkg.sv
// Shared tile-map types: tile codes, default geometry and the writer FSM state type.
package tile_pkg;

    localparam int GRID_BITS_DEF = 4;
    localparam int TYPE_W_DEF    = 4;

    localparam int TILE_EMPTY = 0;  // black
    localparam int TILE_WALL  = 1;  // white
    localparam int TILE_BODY  = 2;  // blue
    localparam int TILE_FOOD  = 3;  // green
    localparam int TILE_HEAD  = 4;  // red

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } tile_state_t;

endpackage

// File: rtl/tile_map_writer_if.sv
// Write-request channel between game logic (master) and the tile map writer (slave).
interface tile_map_writer_if #(
    parameter int GRID_BITS = 4,
    parameter int TYPE_W    = 4
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [GRID_BITS-1:0] wr_x;
    logic [GRID_BITS-1:0] wr_y;
    logic [TYPE_W-1:0]    wr_type;
    logic                 wr_old_valid;
    logic [TYPE_W-1:0]    wr_old_type;

    modport master (
        output wr_valid, wr_x, wr_y, wr_type,
        input  wr_ready, wr_old_valid, wr_old_type
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_type,
        output wr_ready, wr_old_valid, wr_old_type
    );
endinterface

// File: rtl/tile_ram.sv
// Tile map storage: read-first write port with captured old data, plus a registered read port.
module tile_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              old_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] old_q,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rd_q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Array has no reset; only the clear sweep gives it defined contents.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            old_q <= '0;
            rd_q  <= '0;
        end else begin
            if (old_en)
                old_q <= mem[waddr];
            rd_q <= mem[raddr];
        end
    end

endmodule

// File: rtl/tile_map_writer.sv
// Tile map writer: clear sweep after reset/clr_req, then accepts cell writes with old-data return.
// Optional macro TILE_BORDER_WALL_EN: the sweep paints the grid border with TILE_WALL.
module tile_map_writer
    import tile_pkg::*;
#(
    parameter int GRID_BITS = GRID_BITS_DEF,
    parameter int TYPE_W    = TYPE_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    tile_map_writer_if.slave     wr,
    input  logic                 clr_req,
    output logic                 busy,
    input  logic [GRID_BITS-1:0] rd_x,
    input  logic [GRID_BITS-1:0] rd_y,
    output logic [TYPE_W-1:0]    rd_type
);

    localparam int ADDR_W = 2 * GRID_BITS;

    tile_state_t       state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              accept;
    logic [TYPE_W-1:0] fill;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [TYPE_W-1:0] ram_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == '1)
                    state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign busy        = (state == ST_CLEAR);
    assign wr.wr_ready = !rst && (state == ST_IDLE) && !clr_req;
    assign accept      = wr.wr_valid && wr.wr_ready;

`ifdef TILE_BORDER_WALL_EN
    logic [GRID_BITS-1:0] sweep_x, sweep_y;
    assign sweep_x = cnt[GRID_BITS-1:0];
    assign sweep_y = cnt[ADDR_W-1:GRID_BITS];
    assign fill = (sweep_x == '0 || sweep_x == '1 || sweep_y == '0 || sweep_y == '1)
                ? TYPE_W'(TILE_WALL) : TYPE_W'(TILE_EMPTY);
`else
    assign fill = TYPE_W'(TILE_EMPTY);
`endif

    // The single write port is shared: the sweep owns it in CLEAR, game writes in IDLE.
    assign ram_we    = !rst && (busy || accept);
    assign ram_waddr = busy ? cnt  : {wr.wr_y, wr.wr_x};
    assign ram_wdata = busy ? fill : wr.wr_type;

    always_ff @(posedge clk) begin
        if (rst)
            wr.wr_old_valid <= 1'b0;
        else
            wr.wr_old_valid <= accept;
    end

    tile_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (TYPE_W)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (ram_we),
        .old_en (accept),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .old_q  (wr.wr_old_type),
        .raddr  ({rd_y, rd_x}),
        .rd_q   (rd_type)
    );

endmodule

// File: doc/tile_map_writer.md
TILE_MAP_WRITER -- requirements
Module: tile_map_writer

Interface
REQ-001 SHALL have parameter GRID_BITS, default 4, bits per grid coordinate (grid is 2^GRID_BITS square).
REQ-002 SHALL have parameter TYPE_W, default 4, tile-type width.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_valid  input  1  write request from game logic.
REQ-006 wr_ready  output  1  writer can accept a request this cycle.
REQ-007 wr_x, wr_y  input  GRID_BITS each  target cell.
REQ-008 wr_type  input  TYPE_W  tile type to store.
REQ-009 wr_old_valid  output  1  one-cycle pulse; wr_old_type is valid.
REQ-010 wr_old_type  output  TYPE_W  previous contents of the last written cell, for collision detection.
REQ-011 clr_req  input  1  request a full-map clear.
REQ-012 busy  output  1  clear sweep in progress.
REQ-013 rd_x, rd_y  input  GRID_BITS each  display-side lookup cell.
REQ-014 rd_type  output  TYPE_W  registered tile type for (rd_x, rd_y).

Function
REQ-015 SHALL hold a 2^(2*GRID_BITS)-entry x TYPE_W tile map, addressed {y,x}.
REQ-016 SHALL implement FSM states CLEAR and IDLE; rst and an accepted clr_req SHALL enter CLEAR with sweep counter 0.
REQ-017 In CLEAR, SHALL write one cell per cycle at x=cnt[GRID_BITS-1:0], y=cnt[2*GRID_BITS-1:GRID_BITS], then increment cnt.
REQ-018 After writing cell 2^(2*GRID_BITS)-1 (cycle 256 at defaults), SHALL enter IDLE on the next edge; busy = (state==CLEAR).
REQ-019 wr_ready SHALL be 1 only in IDLE with clr_req low; a write is accepted when wr_valid && wr_ready.
REQ-020 On accept, SHALL store wr_type and, on the next cycle, pulse wr_old_valid=1 with wr_old_type = contents before the write (read-first).
REQ-021 clr_req with wr_valid in the same IDLE cycle: clear wins, write not accepted, wr_ready=0.
REQ-022 clr_req during CLEAR SHALL be ignored (sweep not restarted).
REQ-023 Back-to-back accepts to the same cell SHALL return the first write's data as the second's wr_old_type.
REQ-024 rd_type SHALL equal map[{rd_y,rd_x}] one cycle after rd_x/rd_y are presented, in every state; a same-cycle write to that cell returns old data.
REQ-025 Cleared cell value SHALL be TILE_EMPTY (0).

Reset
REQ-026 On rst: state=CLEAR, cnt=0, busy=1, wr_ready=0, wr_old_valid=0, wr_old_type=0, rd_type=0.
REQ-027 rst mid-sweep SHALL restart the sweep at cell 0; map array itself has no reset, only the sweep initialises it.

Configuration
REQ-028 Macro TILE_BORDER_WALL_EN defined: sweep SHALL write TILE_WALL (1) to cells with x or y equal to 0 or 2^GRID_BITS-1, TILE_EMPTY elsewhere.
REQ-029 Macro undefined: sweep SHALL write TILE_EMPTY to every cell; no other behaviour changes.

Structure
REQ-030 Shared package tile_pkg SHALL hold TILE_EMPTY=0, TILE_WALL=1, TILE_BODY=2, TILE_FOOD=3, TILE_HEAD=4 (black/white/blue/green/red), GRID_BITS and TYPE_W defaults.
REQ-031 Sub-module tile_ram SHALL implement the array: one read-first write port (old-data output) and one registered read port.

Verification
REQ-032 Assert rst 1 cycle, release -> busy=1 for 256 cycles, wr_ready rises on cycle 257; rd of (5,7) returns 0 (with TILE_BORDER_WALL_EN, rd of (0,3) returns 1).
REQ-033 IDLE, write (3,4)=2 -> next cycle wr_old_valid=1, wr_old_type=0; rd (3,4) -> rd_type=2 one cycle later.
REQ-034 Write (3,4)=3 then (3,4)=4 back-to-back -> wr_old_type=2 then 3.
REQ-035 clr_req and wr_valid same cycle -> no accept, busy=1 next cycle, written cell reads 0 after sweep.
REQ-036 rst asserted at sweep cell 100 -> sweep restarts at 0, IDLE reached 256 cycles after release.
